// File: rtl/io_serial_pkg.sv
// Shared types and constants for the io_serial_port block.
package io_serial_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 2;
    localparam logic        IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/io_serial_port_if.sv
// Core-side 8-bit I/O port between the CPU and the serial peripheral.
interface io_serial_port_if;
    logic [7:0] ioout;
    logic       iowrite;
    logic       ioread;
    logic [7:0] ioin;
    // Core interrupt line; "int" is a reserved word in SystemVerilog.
    logic       intr;

    modport master (output ioout, output iowrite, output ioread, input ioin, input intr);
    modport slave  (input ioout, input iowrite, input ioread, output ioin, output intr);
endinterface

// File: rtl/io_serial_fifo.sv
// Synchronous FIFO; head reads 0 when empty, push into a full FIFO is accepted with a same-cycle pop.
module io_serial_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign head    = (count == '0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/io_serial_port.sv
// 8N1 UART behind the core's I/O port: TX FIFO -> txd shifter, rxd deframer -> RX FIFO.
module io_serial_port
    import io_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    io_serial_port_if.slave  bus,
    output logic             txd,
    input  logic             rxd,
    output logic             tx_busy,
    output logic             tx_overflow,
    output logic             rx_overrun,
    output logic             frame_err
);
    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned CTW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]     tx_head;
    logic [CTW-1:0] tx_count;
    logic           tx_full;
    logic           tx_empty;
    logic           tx_pop_c;
    ser_state_t     tx_state;
    logic [CW-1:0]  tx_cnt;
    logic [2:0]     tx_bit;
    logic [7:0]     tx_shift;
    logic           tx_end_c;

    logic [CTW-1:0] rx_count;
    logic           rx_full;
    logic           rx_empty;
    logic           rx_pop_c;
    logic           rx_push_c;
    logic           rx_stop_c;
    logic           rx_s1;
    logic           rx_s2;
    ser_state_t     rx_state;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_shift;
    logic           rx_end_c;
    logic           rx_half_c;

    assign tx_empty  = (tx_count == '0);
    assign rx_empty  = (rx_count == '0);
    assign tx_end_c  = (tx_cnt == CW'(CLKS_PER_BIT - 1));
    assign rx_end_c  = (rx_cnt == CW'(CLKS_PER_BIT - 1));
    assign rx_half_c = (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    // Pop on the way into START, either from idle or back-to-back at the end of a stop bit.
    assign tx_pop_c  = !tx_empty && ((tx_state == IDLE) || ((tx_state == STOP) && tx_end_c));
    assign rx_pop_c  = bus.ioread && !rx_empty;
    assign rx_stop_c = (rx_state == STOP) && rx_end_c;
    assign rx_push_c = rx_stop_c && rx_s2;
    assign tx_busy   = (tx_state != IDLE) || !tx_empty;
    assign bus.intr  = !rx_empty;

    io_serial_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.iowrite),
        .pop   (tx_pop_c),
        .wdata (bus.ioout),
        .head  (tx_head),
        .count (tx_count),
        .full  (tx_full)
    );

    io_serial_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push_c),
        .pop   (rx_pop_c),
        .wdata (rx_shift),
        .head  (bus.ioin),
        .count (rx_count),
        .full  (rx_full)
    );

    // Transmitter: txd is registered and changes only on bit boundaries.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= IDLE_LEVEL;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_pop_c) begin
                        tx_shift <= tx_head;
                        txd      <= ~IDLE_LEVEL;
                        tx_cnt   <= '0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_end_c) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tx_end_c) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'(DATA_BITS - 1)) begin
                            txd      <= IDLE_LEVEL;
                            tx_state <= STOP;
                        end else begin
                            txd      <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'(1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tx_end_c) begin
                        tx_cnt <= '0;
                        if (tx_pop_c) begin
                            tx_shift <= tx_head;
                            txd      <= ~IDLE_LEVEL;
                            tx_state <= START;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Receiver: synchronised rxd, sampled at bit centres from a half-bit start check.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1    <= IDLE_LEVEL;
            rx_s2    <= IDLE_LEVEL;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    if (rx_s2 != IDLE_LEVEL) rx_state <= START;
                end
                START: begin
                    if (rx_half_c) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= (rx_s2 != IDLE_LEVEL) ? DATA : IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (rx_end_c) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'(DATA_BITS - 1)) rx_state <= STOP;
                        else                             rx_bit   <= rx_bit + 3'(1);
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (rx_end_c) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // Sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (bus.iowrite && tx_full && !tx_pop_c) tx_overflow <= 1'b1;
            if (rx_push_c && rx_full && !rx_pop_c)   rx_overrun  <= 1'b1;
            if (rx_stop_c && !rx_s2)                 frame_err   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_io_serial_port.sv
// Self-checking bench for io_serial_port with a queue-based reference model of the serial link.
module tb_io_serial_port;
    import io_serial_pkg::*;

    localparam int unsigned C     = 4;
    localparam int unsigned D     = 4;
    localparam int          FRAME = FRAME_BITS * C;

    logic clock = 1'b0;
    logic reset;
    logic txd;
    logic rxd;
    logic tx_busy;
    logic tx_overflow;
    logic rx_overrun;
    logic frame_err;

    io_serial_port_if bus();

    io_serial_port #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .txd         (txd),
        .rxd         (rxd),
        .tx_busy     (tx_busy),
        .tx_overflow (tx_overflow),
        .rx_overrun  (rx_overrun),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    int   vectors    = 0;
    int   miscompares = 0;
    logic [7:0] rxq[$];
    logic exp_ovr;
    logic exp_ferr;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Line level of bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_level(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    task automatic do_reset();
        reset       = 1'b1;
        bus.iowrite = 1'b0;
        bus.ioread  = 1'b0;
        bus.ioout   = 8'h00;
        rxd         = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        rxq.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // Drives one rxd frame plus one idle bit; optional ioread on the push edge. Updates the model.
    task automatic send_frame(input logic [7:0] b, input logic good_stop, input logic rd_at_push);
        for (int s = 0; s < FRAME + int'(C); s++) begin
            if (s < FRAME) rxd = (s / C == 9) ? good_stop : frame_level(b, s / C);
            else           rxd = 1'b1;
            bus.ioread = rd_at_push && (s == FRAME);
            step();
        end
        bus.ioread = 1'b0;
        if (rd_at_push && rxq.size() > 0) void'(rxq.pop_front());
        if (!good_stop)            exp_ferr = 1'b1;
        else if (rxq.size() < D)   rxq.push_back(b);
        else                       exp_ovr = 1'b1;
    endtask

    task automatic do_read();
        bus.ioread = 1'b1;
        step();
        bus.ioread = 1'b0;
        if (rxq.size() > 0) void'(rxq.pop_front());
    endtask

    // Writes bytes on consecutive cycles and checks the whole txd waveform and tx_busy.
    task automatic run_tx(input logic [7:0] q[$], input string name);
        int n     = q.size();
        int sent  = (n > int'(D) + 1) ? int'(D) + 1 : n;
        int total = sent * FRAME;
        logic exp;
        for (int c = 0; c <= total + 2; c++) begin
            if (c >= 2 && c - 2 < total) begin
                exp = frame_level(q[(c-2) / FRAME], ((c-2) % FRAME) / int'(C));
                vectors++;
                if (txd !== exp) begin
                    miscompares++;
                    $display("FAIL %s txd: got %b expected %b at cycle %0d", name, txd, exp, c);
                end
            end
            if (c >= 1 && c <= total + 1) begin
                vectors++;
                if (tx_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s tx_busy: got %b expected 1 at cycle %0d", name, tx_busy, c);
                end
            end
            if (c == total + 2) begin
                vectors++;
                if (txd !== 1'b1 || tx_busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s idle: got txd=%b busy=%b expected txd=1 busy=0", name, txd, tx_busy);
                end
            end
            bus.iowrite = (c < n);
            bus.ioout   = (c < n) ? q[c] : 8'h00;
            step();
        end
        bus.iowrite = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({txd, bus.intr, bus.ioin, tx_busy, tx_overflow, rx_overrun, frame_err} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset: txd=%b int=%b ioin=%h busy=%b ovf=%b ovr=%b ferr=%b expected 1 0 00 0 0 0 0",
                     txd, bus.intr, bus.ioin, tx_busy, tx_overflow, rx_overrun, frame_err);
        end
    endtask

    task automatic test_reset_midframe();
        bus.iowrite = 1'b1;
        bus.ioout   = 8'h00;
        step();
        bus.iowrite = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        vectors++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midframe: txd=%b busy=%b expected 1 0", txd, tx_busy);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_tx_single();
        logic [7:0] q[$];
        q = '{8'hA5};
        run_tx(q, "tx_single");
        vectors++;
        if (tx_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_single overflow: got %b expected 0", tx_overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_tx(q, "tx_burst");
        vectors++;
        if (tx_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_burst overflow: got %b expected 1", tx_overflow);
        end
    endtask

    task automatic test_tx_random();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] q[$];
            int n = int'($urandom_range(1, D + 1));
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            run_tx(q, "tx_random");
        end
    endtask

    task automatic test_rx_single();
        send_frame(8'h3C, 1'b1, 1'b0);
        vectors++;
        if (bus.intr !== 1'b1 || bus.ioin !== 8'h3C) begin
            miscompares++;
            $display("FAIL rx_single: int=%b ioin=%h expected 1 3c", bus.intr, bus.ioin);
        end
        do_read();
        vectors++;
        if (bus.intr !== 1'b0 || bus.ioin !== 8'h00) begin
            miscompares++;
            $display("FAIL rx_single pop: int=%b ioin=%h expected 0 00", bus.intr, bus.ioin);
        end
    endtask

    task automatic test_rx_glitch_ferr();
        rxd = 1'b0;
        step();
        rxd = 1'b1;
        repeat (3 * C) step();
        vectors++;
        if (bus.intr !== 1'b0 || frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_glitch: int=%b ferr=%b ovr=%b expected 0 0 0", bus.intr, frame_err, rx_overrun);
        end
        send_frame(8'h5A, 1'b0, 1'b0);
        repeat (C) step();
        vectors++;
        if (frame_err !== exp_ferr || bus.intr !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_frame_err: ferr=%b int=%b expected %b 0", frame_err, bus.intr, exp_ferr);
        end
    endtask

    task automatic test_rx_overrun();
        do_reset();
        for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
        vectors++;
        if (rx_overrun !== exp_ovr || bus.ioin !== rxq[0] || exp_ovr !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_overrun: ovr=%b ioin=%h expected 1 %h", rx_overrun, bus.ioin, rxq[0]);
        end
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b1);
        vectors++;
        if (rx_overrun !== 1'b0 || bus.intr !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_push_pop_full: ovr=%b int=%b expected 0 1", rx_overrun, bus.intr);
        end
        for (int i = 0; i < int'(D); i++) begin
            vectors++;
            if (bus.ioin !== rxq[0]) begin
                miscompares++;
                $display("FAIL rx_drain[%0d]: ioin=%h expected %h", i, bus.ioin, rxq[0]);
            end
            do_read();
        end
        vectors++;
        if (bus.intr !== 1'b0 || bus.ioin !== 8'h00) begin
            miscompares++;
            $display("FAIL rx_drain empty: int=%b ioin=%h expected 0 00", bus.intr, bus.ioin);
        end
    endtask

    task automatic test_rx_random();
        logic [7:0] exp_head;
        do_reset();
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 2) != 0)
                send_frame(8'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
            else
                do_read();
            exp_head = (rxq.size() > 0) ? rxq[0] : 8'h00;
            vectors++;
            if (bus.ioin !== exp_head || bus.intr !== (rxq.size() > 0) ||
                rx_overrun !== exp_ovr || frame_err !== exp_ferr) begin
                miscompares++;
                $display("FAIL rx_random[%0d]: ioin=%h int=%b ovr=%b ferr=%b expected %h %b %b %b",
                         it, bus.ioin, bus.intr, rx_overrun, frame_err,
                         exp_head, (rxq.size() > 0), exp_ovr, exp_ferr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_tx_single();
        test_back_to_back();
        test_tx_random();
        test_rx_single();
        test_rx_glitch_ferr();
        test_rx_overrun();
        test_rx_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/io_serial_port.md
Name: io_serial_port

Overview:
Serial peripheral that answers the CPU core's 8-bit I/O port (ioout/iowrite/ioread/ioin/int). Bytes written by the core are queued in a TX FIFO and shifted out as 8N1 asynchronous serial on txd. Serial frames arriving on rxd are deframed into an RX FIFO, whose head the core reads through ioin. The block asserts the core's interrupt while received data is pending.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; integer ≥4, even.
FIFO_DEPTH, 4, entries per FIFO; power of two, ≥2.

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  synchronous, active-high; clears all state
ioout  input  8  write data from core; valid when iowrite=1
iowrite  input  1  one-cycle write strobe from core; pushes ioout into TX FIFO
ioread  input  1  one-cycle read strobe from core; pops RX FIFO
ioin  output  8  RX FIFO head (combinational from FIFO state); 0x00 when RX FIFO empty
int  output  1  high while RX FIFO non-empty; drives core int
txd  output  1  serial out, idle high
rxd  input  1  serial in, asynchronous
tx_busy  output  1  high while TX FSM not IDLE or TX FIFO non-empty
tx_overflow  output  1  sticky: write arrived with TX FIFO full
rx_overrun  output  1  sticky: received byte dropped, RX FIFO full
frame_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (sync, high): FIFOs emptied; TX/RX FSMs to IDLE; counters 0; txd=1; rxd synchroniser flops =1; all flags 0; ioin=0x00; int=0; tx_busy=0. Reset mid-frame aborts the frame; txd=1 from the next cycle.
- Core I/O protocol: core samples ioin in the same cycle ioread=1; pop takes effect at that edge. ioread on empty RX FIFO: no pop, no flag.
- iowrite with TX FIFO full: byte dropped, tx_overflow set. Pushes and pops in the same cycle are both honoured; a write to a full TX FIFO in the same cycle as a TX pop succeeds.
- TX FSM IDLE→START→DATA→STOP. IDLE pops FIFO when non-empty and enters START at that edge. START: txd=0 for CLKS_PER_BIT cycles. DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. STOP: txd=1 for CLKS_PER_BIT cycles. At the end of STOP: if FIFO non-empty, pop and go directly to START (no idle gap); else IDLE.
- TX latency: byte captured at edge E (FIFO was empty, FSM IDLE); pop at E+1; txd low from E+1 for CLKS_PER_BIT cycles. One frame lasts 10×CLKS_PER_BIT cycles.
- RX: rxd passes through a 2-flop synchroniser; the FSM uses its output. FSM IDLE→START→DATA→STOP.
  - IDLE: low level enters START.
  - START: wait CLKS_PER_BIT/2 cycles and resample. If still low, go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles (bit centres), shifting in LSB first.
  - STOP: sample at the stop-bit centre.
    - High: push byte. If RX FIFO full and no ioread that cycle, drop the byte and set rx_overrun.
    - Low: discard the byte, set frame_err.
  - From STOP, return to IDLE right after the stop sample; a new start edge can then be detected.
- Push and ioread in the same cycle on a full RX FIFO: both occur, no overrun.
- Sticky flags clear only on reset.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits; full is count==FIFO_DEPTH.

Decomposition:
- Package io_serial_pkg: TX/RX state enums (IDLE, START, DATA, STOP), FRAME_BITS=10, IDLE_LEVEL=1'b1.
- Sub-module io_serial_fifo (synchronous FIFO; push/pop/full/empty/head/count; simultaneous push+pop legal when full), instantiated twice (TX, RX).

Test Plan:
1. Assert reset 2 cycles, release -> txd=1, int=0, ioin=0x00, tx_busy=0, all flags 0.
2. CLKS_PER_BIT=4: iowrite 0xA5 -> txd reads 0,1,0,1,0,0,1,0,1,1, each level 4 cycles (40 cycles total), starting 1 cycle after capture; tx_busy high throughout, low after stop.
3. iowrite 6 bytes on consecutive cycles (0x01..0x06), depth 4 -> 0x01..0x05 sent as 5 gapless frames (200 cycles); 0x06 dropped; tx_overflow=1.
4. Drive an rxd frame carrying 0x3C -> at the stop-bit centre int=1, ioin=0x3C; pulse ioread -> next cycle int=0, ioin=0x00.
5. rxd low for 1 cycle only -> no byte, no flags. Then a full frame with stop bit low -> frame_err=1, int stays 0.
6. Receive 5 frames (0x10..0x14) without reads -> rx_overrun=1, ioin=0x10. Refill to full, then a 5th frame completes in the same cycle as ioread -> no new overrun; FIFO still holds 4 entries.
